// File: rtl/light_hash_stream.sv
// Streaming character hash: each accepted character is absorbed into an NBLK-byte state by
// ROUNDS applications of an AES S-box round, one round per clock; the last character emits the digest.
module light_hash_stream #(
    parameter int NBLK    = 8,
    parameter int ROUNDS  = 32,
    parameter int CHARSET = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            msg_char,
    input  logic                  msg_valid,
    input  logic                  msg_last,
    output logic                  msg_ready,
    output logic [8*NBLK-1:0]     digest,
    output logic                  digest_valid,
    output logic                  err_invalid_char
);

    typedef enum logic [0:0] {IDLE = 1'b0, ROUND = 1'b1} state_t;

    localparam logic [7:0]  RC_LAST = 8'(ROUNDS - 1);
    localparam logic [63:0] IVB     = 64'hEE2BC0DA140F5534;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    // The 8-byte IV repeats across the state when NBLK exceeds 8.
    function automatic logic [8*NBLK-1:0] iv_init();
        logic [8*NBLK-1:0] v;
        v = {(8*NBLK){1'b0}};
        for (int i = 0; i < NBLK; i++) begin
            v[8*i +: 8] = IVB[8*(i%8) +: 8];
        end
        return v;
    endfunction

    localparam logic [8*NBLK-1:0] IV = iv_init();

    function automatic logic char_ok(input logic [7:0] c);
        if (CHARSET == 0) begin
            return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h5A)) ||
                   ((c >= 8'h61) && (c <= 8'h7A));
        end else begin
            return (c >= 8'h20) && (c <= 8'h7E);
        end
    endfunction

    state_t             state_r, state_nxt_s;
    logic [7:0]         rc_r;
    logic [7:0]         char_r;
    logic               last_r;
    logic               bad_r;
    logic               ready_r;
    logic [8*NBLK-1:0]  h_r, h_nxt_s;
    logic [8*NBLK-1:0]  digest_r, fin_digest_s;
    logic               digest_valid_r;
    logic               err_r;
    logic [7:0]         mix_s;
    logic               accept_s, char_ok_s, start_s, bad_accept_s;
    logic               round_s, round_done_s, fin_s;

    assign accept_s  = msg_valid & ready_r;
    assign char_ok_s = char_ok(msg_char);

    // Next-state and control strobes for the IDLE/ROUND sequencer.
    always_comb begin
        state_nxt_s  = state_r;
        start_s      = 1'b0;
        bad_accept_s = 1'b0;
        round_s      = 1'b0;
        round_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && char_ok_s) begin
                    state_nxt_s = ROUND;
                    start_s     = 1'b1;
                end else if (accept_s) begin
                    bad_accept_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ROUND: begin
                round_s = 1'b1;
                if (rc_r == RC_LAST) begin
                    round_done_s = 1'b1;
                    state_nxt_s  = IDLE;
                end else begin
                    state_nxt_s = ROUND;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // One round: blocks update in index order, so later blocks see earlier new values.
    always_comb begin
        h_nxt_s = h_r;
        mix_s   = 8'h00;
        for (int i = 0; i < NBLK; i++) begin
            mix_s               = h_nxt_s[8*((i+2)%NBLK) +: 8] ^ char_r;
            h_nxt_s[8*i +: 8]   = sbox(8'(mix_s << (i%8)));
        end
    end

    // Finalisation happens on the last round of a last character, or on an invalid last character.
    always_comb begin
        fin_s = (round_done_s & last_r) | (bad_accept_s & msg_last);
        if (round_done_s && !bad_r) begin
            fin_digest_s = h_nxt_s;
        end else begin
            fin_digest_s = {(8*NBLK){1'b0}};
        end
    end

    // FSM state and registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == IDLE);
        end
    end

    // Round counter and latched character/last flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc_r   <= 8'd0;
            char_r <= 8'h00;
            last_r <= 1'b0;
        end else if (start_s) begin
            rc_r   <= 8'd0;
            char_r <= msg_char;
            last_r <= msg_last;
        end else if (round_s) begin
            rc_r <= round_done_s ? 8'd0 : rc_r + 8'd1;
        end
    end

    // Hash state and message-bad flag; both return to their initial values on finalisation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_r   <= IV;
            bad_r <= 1'b0;
        end else begin
            if (fin_s) begin
                h_r <= IV;
            end else if (round_s) begin
                h_r <= h_nxt_s;
            end
            if (fin_s) begin
                bad_r <= 1'b0;
            end else if (bad_accept_s) begin
                bad_r <= 1'b1;
            end
        end
    end

    // Registered digest and strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digest_r       <= {(8*NBLK){1'b0}};
            digest_valid_r <= 1'b0;
            err_r          <= 1'b0;
        end else begin
            if (fin_s) begin
                digest_r <= fin_digest_s;
            end
            digest_valid_r <= fin_s;
            err_r          <= bad_accept_s;
        end
    end

    assign msg_ready        = ready_r;
    assign digest           = digest_r;
    assign digest_valid     = digest_valid_r;
    assign err_invalid_char = err_r;

endmodule

// File: tb/tb_light_hash_stream.sv
// Bench for light_hash_stream: three configurations driven by directed and random messages,
// checked against a reference hash built from a GF(2^8)-derived S-box.
module tb_light_hash_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  msg_char;
    logic        msg_last;
    logic [2:0]  msg_valid;
    logic [2:0]  ready, dv, err;
    logic [63:0] dg0, dg1;
    logic [31:0] dg2;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    light_hash_stream dut0 (
        .clk(clk), .rst_n(rst_n), .msg_char(msg_char), .msg_valid(msg_valid[0]), .msg_last(msg_last),
        .msg_ready(ready[0]), .digest(dg0), .digest_valid(dv[0]), .err_invalid_char(err[0]));

    light_hash_stream #(.CHARSET(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .msg_char(msg_char), .msg_valid(msg_valid[1]), .msg_last(msg_last),
        .msg_ready(ready[1]), .digest(dg1), .digest_valid(dv[1]), .err_invalid_char(err[1]));

    light_hash_stream #(.NBLK(4), .ROUNDS(1), .CHARSET(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .msg_char(msg_char), .msg_valid(msg_valid[2]), .msg_last(msg_last),
        .msg_ready(ready[2]), .digest(dg2), .digest_valid(dv[2]), .err_invalid_char(err[2]));

    int          checks = 0;
    int          errors = 0;
    int          NB [3] = '{8, 8, 4};
    int          RN [3] = '{32, 32, 1};
    int          CS [3] = '{0, 1, 0};
    int          IVB [8] = '{'h34, 'h55, 'h0F, 'h14, 'hDA, 'hC0, 'h2B, 'hEE};
    int          dv_cnt [3], dv_cyc [3], err_cnt [3], err_cyc [3], low_cnt [3];
    logic [63:0] dv_val [3];
    logic [7:0]  sb [256];
    logic [7:0]  msg_q [$];
    int          acc [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        int p = 0;
        for (int k = 0; k < 8; k++) begin
            if ((b & 1) != 0) p = p ^ a;
            a = a << 1;
            if ((a & 'h100) != 0) a = a ^ 'h11B;
            b = b >> 1;
        end
        return p & 255;
    endfunction

    function automatic int rotl8(input int v, input int n);
        return ((v << n) | (v >> (8 - n))) & 255;
    endfunction

    // S-box from first principles: multiplicative inverse followed by the AES affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            int inv = 0;
            if (x != 0) begin
                inv = 1;
                repeat (254) inv = gmul(inv, x);
            end
            sb[x] = 8'(inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 'h63);
        end
    endtask

    function automatic bit legal(input int c, input int cs);
        if (cs == 0) return (c >= 48 && c <= 57) || (c >= 65 && c <= 90) || (c >= 97 && c <= 122);
        return (c >= 32 && c <= 126);
    endfunction

    // Digest of msg_q for configuration s (zero if any character is illegal).
    function automatic logic [63:0] model(input int s);
        int          h [16];
        bit          bad = 0;
        logic [63:0] r = 64'h0;
        for (int i = 0; i < NB[s]; i++) h[i] = IVB[i % 8];
        foreach (msg_q[k]) begin
            int c = int'(msg_q[k]);
            if (!legal(c, CS[s])) bad = 1;
            else begin
                repeat (RN[s]) begin
                    for (int i = 0; i < NB[s]; i++) h[i] = int'(sb[((h[(i + 2) % NB[s]] ^ c) << (i % 8)) & 255]);
                end
            end
        end
        if (!bad) for (int i = 0; i < NB[s]; i++) r[8*i +: 8] = 8'(h[i]);
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            if (dv[s]) begin
                dv_cnt[s]++;
                dv_cyc[s] = cyc;
                dv_val[s] = (s == 0) ? dg0 : (s == 1) ? dg1 : {32'h0, dg2};
            end
            if (err[s]) begin
                err_cnt[s]++;
                err_cyc[s] = cyc;
            end
            if (!ready[s]) low_cnt[s]++;
        end
    endtask

    // Streams msg_q into DUT s with valid held high; records the edge of each accept.
    task automatic send(input int s);
        acc.delete();
        for (int i = 0; i < msg_q.size(); i++) begin
            int guard = 0;
            msg_char     = msg_q[i];
            msg_last     = (i == msg_q.size() - 1);
            msg_valid[s] = 1'b1;
            while (!ready[s] && guard < 400) begin
                tick();
                guard++;
            end
            if (guard >= 400) begin
                chk("ready_timeout", 64'(guard), 64'd0);
                break;
            end
            tick();
            acc.push_back(cyc);
        end
        msg_valid[s] = 1'b0;
        msg_last     = 1'b0;
    endtask

    task automatic run(input int s, input string tag);
        logic [63:0] exp;
        int          d0, off;
        exp = model(s);
        off = legal(int'(msg_q[msg_q.size() - 1]), CS[s]) ? RN[s] : 0;
        d0  = dv_cnt[s];
        low_cnt[s] = 0;
        send(s);
        repeat (RN[s] + 4) tick();
        chk({tag, "_dv_count"}, 64'(dv_cnt[s] - d0), 64'd1);
        chk({tag, "_digest"}, dv_val[s], exp);
        chk({tag, "_dv_time"}, 64'(dv_cyc[s] - acc[acc.size() - 1]), 64'(off));
    endtask

    string       alnum = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz";
    logic [63:0] first;
    int          e0, e1, d0;

    initial begin
        rst_n = 1'b0; msg_char = 8'h00; msg_last = 1'b0; msg_valid = 3'b000;
        for (int s = 0; s < 3; s++) begin
            dv_cnt[s] = 0; dv_cyc[s] = 0; err_cnt[s] = 0; err_cyc[s] = 0; low_cnt[s] = 0; dv_val[s] = 64'h0;
        end
        build_sbox();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_ready", {61'h0, ready}, 64'h7);
        chk("rst_dv", {61'h0, dv}, 64'h0);
        chk("rst_err", {61'h0, err}, 64'h0);
        chk("rst_digest0", dg0, 64'h0);
        chk("rst_digest2", {32'h0, dg2}, 64'h0);

        // Single 'A' with defaults.
        msg_q = '{8'h41};
        run(0, "t1");
        chk("t1_ready_low", 64'(low_cnt[0]), 64'd32);

        // "Ab9" twice: accept spacing and IV reload.
        msg_q = '{8'h41, 8'h62, 8'h39};
        run(0, "t2a");
        chk("t2_gap1", 64'(acc[1] - acc[0]), 64'd33);
        chk("t2_gap2", 64'(acc[2] - acc[1]), 64'd33);
        chk("t2_total", 64'(dv_cyc[0] - acc[0]), 64'd98);
        first = dv_val[0];
        run(0, "t2b");
        chk("t2_repeat", dv_val[0], first);

        // "A#b" under both charsets.
        msg_q = '{8'h41, 8'h23, 8'h62};
        e0 = err_cnt[0];
        run(0, "t3cs0");
        chk("t3_err_count", 64'(err_cnt[0] - e0), 64'd1);
        chk("t3_err_time", 64'(err_cyc[0]), 64'(acc[1]));
        e1 = err_cnt[1];
        run(1, "t3cs1");
        chk("t3_cs1_err_count", 64'(err_cnt[1] - e1), 64'd0);

        // Invalid last character.
        msg_q = '{8'h7F};
        e0 = err_cnt[0];
        run(0, "t4");
        chk("t4_err_count", 64'(err_cnt[0] - e0), 64'd1);
        chk("t4_err_time", 64'(err_cyc[0]), 64'(acc[0]));

        // Small configuration.
        msg_q = '{8'h7A};
        run(2, "t5");

        // Random messages on all three configurations.
        for (int r = 0; r < 6; r++) begin
            int len = $urandom_range(1, 4);
            msg_q.delete();
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) msg_q.push_back(8'($urandom_range(32, 126)));
                else msg_q.push_back(alnum[$urandom_range(0, 61)]);
            end
            for (int s = 0; s < 3; s++) run(s, $sformatf("rnd%0d_s%0d", r, s));
        end

        // Reset in the middle of ROUND, after a non-zero digest.
        msg_q = '{8'h48, 8'h69};
        run(0, "t6pre");
        msg_q = '{8'h51};
        msg_char = 8'h51; msg_last = 1'b1; msg_valid[0] = 1'b1;
        tick();
        msg_valid[0] = 1'b0; msg_last = 1'b0;
        repeat (5) tick();
        #3 rst_n = 1'b0;
        #1;
        chk("t6_async_ready", {63'h0, ready[0]}, 64'h1);
        chk("t6_async_digest", dg0, 64'h0);
        chk("t6_async_dv", {63'h0, dv[0]}, 64'h0);
        tick();
        rst_n = 1'b1;
        d0 = dv_cnt[0];
        repeat (40) tick();
        chk("t6_no_dv", 64'(dv_cnt[0] - d0), 64'd0);
        run(0, "t6post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
